// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: widths, state encoding, NOP constant and the
// instr/pc bundle handed to the decoder.
package fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    // ADDI x0,x0,0
    localparam logic [INSTR_W-1:0] FETCH_NOP = 32'h0000_0013;
    localparam logic [PC_W-1:0]    PC_STEP   = PC_W'(4);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus4;
    } fetch_out_t;

    function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: req/gnt address phase, rvalid data phase.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: sequential +4 advance, redirect load and sticky
// misaligned-target detection.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_pc,
    input  logic            i_advance,
    output logic [PC_W-1:0] o_fetch_pc,
    output logic [PC_W-1:0] o_fetch_pc_plus4_c,
    output logic            o_misalign,
    output logic            o_bad_target_c
);

    logic [PC_W-1:0] r_fetch_pc;
    logic            r_misalign;
    logic            w_bad_target;

    assign w_bad_target = is_misaligned(i_redirect_pc);

    // A misaligned target never reaches the PC; it only latches the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (i_redirect) begin
            if (w_bad_target) begin
                r_misalign <= 1'b1;
            end else begin
                r_fetch_pc <= i_redirect_pc;
            end
        end else if (i_advance) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    assign o_fetch_pc         = r_fetch_pc;
    assign o_fetch_pc_plus4_c = r_fetch_pc + PC_STEP;
    assign o_misalign         = r_misalign;
    assign o_bad_target_c     = w_bad_target;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read at a time, holds the returned word
// for the decoder until consumed, squashes stale data after redirect/reset.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus4,
    output logic               instr_valid,
    output logic               misalign
);

    fetch_state_t    r_state;
    logic            r_drop;
    logic            r_valid;
    fetch_out_t      r_out;

    logic [PC_W-1:0] w_fetch_pc;
    logic [PC_W-1:0] w_fetch_pc_plus4;
    logic            w_redirect;
    logic            w_bad_target;
    logic            w_advance;

    // HALT ignores redirects entirely.
    assign w_redirect = redirect && (r_state != ST_HALT);
    assign w_advance  = (r_state == ST_WAIT) && imem.imem_rvalid && !r_drop && !w_redirect;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk                (clk),
        .rst                (rst),
        .i_redirect         (w_redirect),
        .i_redirect_pc      (redirect_pc),
        .i_advance          (w_advance),
        .o_fetch_pc         (w_fetch_pc),
        .o_fetch_pc_plus4_c (w_fetch_pc_plus4),
        .o_misalign         (misalign),
        .o_bad_target_c     (w_bad_target)
    );

    // Reset remembers whether a granted read is still in flight so its
    // response can be absorbed in IDLE instead of being taken as data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_drop         <= (r_state == ST_WAIT) || ((r_state == ST_FETCH) && imem.imem_gnt);
            r_valid        <= 1'b0;
            r_out.instr    <= NOP_INSTR;
            r_out.pc       <= RESET_PC;
            r_out.pc_plus4 <= RESET_PC + PC_STEP;
        end else if (w_redirect) begin
            r_valid     <= 1'b0;
            r_out.instr <= NOP_INSTR;
            if (w_bad_target) begin
                r_state <= ST_HALT;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (imem.imem_gnt) begin
                            r_state <= ST_WAIT;
                            r_drop  <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem.imem_rvalid) begin
                            r_state <= ST_FETCH;
                            r_drop  <= 1'b0;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end
                    ST_HOLD: r_state <= ST_FETCH;
                    default: ;
                endcase
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_drop || imem.imem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_gnt) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_out.instr    <= imem.imem_rdata;
                            r_out.pc       <= w_fetch_pc;
                            r_out.pc_plus4 <= w_fetch_pc_plus4;
                            r_valid        <= 1'b1;
                            r_state        <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        r_valid     <= 1'b0;
                        r_out.instr <= NOP_INSTR;
                        r_state     <= ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem.imem_req  = (r_state == ST_FETCH);
    assign imem.imem_addr = w_fetch_pc;

    assign instr       = r_out.instr;
    assign pc          = r_out.pc;
    assign pc_plus4    = r_out.pc_plus4;
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random memory timing, stalls
// and redirects, checked by a scoreboard of expected instruction addresses.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, misalign;

    int errors = 0;
    int checks = 0;
    int consumed = 0;
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;

    logic [31:0] exp_q[$];

    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    // Memory image: every word is distinct and address-dependent.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h0010_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name, output logic [31:0] addr);
        addr = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) begin
                addr = bus.imem_addr;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: got no grant in 100 cycles, expected a granted request", name);
    endtask

    task automatic wait_valid(input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (instr_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: got instr_valid=0 for 100 cycles, expected 1", name);
    endtask

    // Memory responder: random grant, one read outstanding, latency lat_min..lat_max.
    initial begin
        int          pend;
        logic [31:0] paddr;
        pend  = 0;
        paddr = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            step();
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom();
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(paddr);
                end
            end else if (bus.imem_req && ($urandom_range(99) < 32'(gnt_pct))) begin
                bus.imem_gnt = 1'b1;
                paddr        = bus.imem_addr;
                pend         = int'($urandom_range(32'(lat_max), 32'(lat_min)));
            end
        end
    end

    // Scoreboard: queue head is the address the next delivered instruction must have.
    initial begin
        logic [31:0] p;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_q.push_back(RST_PC);
            end else begin
                if (instr_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_valid", {31'b0, instr_valid}, 32'h0);
                    end else begin
                        chk("sb_pc", pc, exp_q[0]);
                        chk("sb_instr", instr, mem_word(exp_q[0]));
                        chk("sb_pc_plus4", pc_plus4, exp_q[0] + 32'd4);
                    end
                end else begin
                    chk("sb_nop_idle", instr, NOP);
                end
                if (redirect) begin
                    exp_q.delete();
                    if (redirect_pc[1:0] == 2'b00) exp_q.push_back(redirect_pc);
                end else if (instr_valid && !stall && exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    exp_q.push_back(p + 32'd4);
                    consumed++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by 500000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, RST_PC);
        chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        step();
        rst = 1'b0;

        // basic fetch
        wait_gnt("t1_gnt", a);
        chk("t1_addr", a, 32'h0);
        wait_valid("t1_valid");
        chk("t1_instr", instr, 32'h0010_0093);
        chk("t1_pc", pc, 32'h0);
        chk("t1_pc_plus4", pc_plus4, 32'h4);
        wait_gnt("t1_gnt2", a);
        chk("t1_next_addr", a, 32'h4);

        // stall holds the instruction
        step();
        stall = 1'b1;
        wait_valid("t2_valid");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("t2_hold_req", {31'b0, bus.imem_req}, 32'd0);
            chk("t2_hold_pc", pc, 32'h4);
        end
        step();
        stall = 1'b0;
        step();
        @(negedge clk);
        chk("t2_release_valid", {31'b0, instr_valid}, 32'd0);
        chk("t2_release_req", {31'b0, bus.imem_req}, 32'd1);
        chk("t2_release_addr", bus.imem_addr, 32'h8);

        // redirect while waiting for data
        lat_min = 3;
        lat_max = 3;
        wait_gnt("t3_gnt", a);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0;
        wait_gnt("t3_gnt2", a);
        chk("t3_redirect_addr", a, 32'h100);
        wait_valid("t3_valid");
        chk("t3_pc", pc, 32'h100);

        // wrap at top of address space
        lat_min = 1;
        lat_max = 1;
        step();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        wait_valid("t6_valid");
        chk("t6_pc", pc, 32'hFFFF_FFFC);
        chk("t6_pc_plus4", pc_plus4, 32'h0);
        wait_gnt("t6_gnt", a);
        chk("t6_wrap_addr", a, 32'h0);

        // reset in WAIT with a stale response after release
        lat_min = 3;
        lat_max = 3;
        wait_gnt("t5_gnt", a);
        chk("t5_pre_addr", a, 32'h4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_gnt("t5_gnt2", a);
        chk("t5_first_addr", a, RST_PC);
        wait_valid("t5_valid");
        chk("t5_pc", pc, RST_PC);

        // misaligned redirect halts until reset
        step();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_misalign", {31'b0, misalign}, 32'd1);
            chk("t4_req", {31'b0, bus.imem_req}, 32'd0);
            chk("t4_valid", {31'b0, instr_valid}, 32'd0);
        end
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_misalign", {31'b0, misalign}, 32'd0);

        // random traffic
        gnt_pct = 60;
        lat_min = 1;
        lat_max = 4;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            stall    = ($urandom_range(99) < 30);
            redirect = ($urandom_range(99) < 4);
            case ($urandom_range(9))
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = {22'b0, 8'($urandom()), 2'b00};
            endcase
        end
        step();
        stall = 1'b0;
        redirect = 1'b0;
        repeat (20) step();
        checks++;
        if (consumed < 50) begin
            errors++;
            $display("FAIL rand_progress: got %0d consumed, expected at least 50", consumed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
